// File: rtl/fe_inv.sv
// Curve25519 field inverter: out = in^(p-2) mod p, p = 2^255-19, through an external
// pipelined field multiplier using a fixed left-to-right square-and-multiply schedule.
//
// state | meaning
// IDLE  | waiting for an operand; holds the result until the consumer takes it
// ISSUE | registers multiplier operands (r*r for SQR, r*x for MUL)
// WAIT  | down-counts the multiplier latency, then captures mul_result into r
module fe_inv #(
   parameter int MUL_LAT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [254:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [254:0] out_data_o,
   output logic         busy_o,
   output logic [255:0] mul_a_o,
   output logic [255:0] mul_b_o,
   input  logic [254:0] mul_result_i
);

   localparam logic [254:0] P      = 255'h0 - 255'd19;
   // low five bits of the exponent p-2; every bit above them is 1
   localparam logic [7:0]   EXP_LO = 8'b0000_1011;
   localparam logic [7:0]   LAT_M1 = 8'(MUL_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic {PH_SQR, PH_MUL} phase_t;

   state_t         state_q, state_d;
   phase_t         phase_q, phase_d;
   logic [254:0]   x_q, x_d;
   logic [254:0]   r_q, r_d;
   logic [7:0]     i_q, i_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [255:0]   mul_a_q, mul_a_d;
   logic [255:0]   mul_b_q, mul_b_d;
   logic           out_valid_q, out_valid_d;
   logic [254:0]   out_data_q, out_data_d;
   logic           busy_q, busy_d;
   logic           accept;

   function automatic logic [254:0] canon(input logic [254:0] v);
      return (v >= P) ? (v - P) : v;
   endfunction

   function automatic logic exp_bit(input logic [7:0] idx);
      return (idx >= 8'd5) ? 1'b1 : EXP_LO[idx[2:0]];
   endfunction

   assign in_ready_o  = (state_q == S_IDLE) && !out_valid_q;
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = busy_q;
   assign mul_a_o     = mul_a_q;
   assign mul_b_o     = mul_b_q;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      x_d         = x_q;
      r_d         = r_q;
      i_d         = i_q;
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               // exponent bit 254 is consumed by starting with r = x
               x_d     = canon(in_data_i);
               r_d     = canon(in_data_i);
               i_d     = 8'd253;
               phase_d = PH_SQR;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mul_a_d = {1'b0, r_q};
            mul_b_d = {1'b0, (phase_q == PH_SQR) ? r_q : x_q};
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               r_d = mul_result_i;
               if ((phase_q == PH_SQR) && exp_bit(i_q)) begin
                  phase_d = PH_MUL;
                  state_d = S_ISSUE;
               end else if (i_q == 8'd0) begin
                  // the final product may be non-canonical; reduce it on the way out
                  out_data_d  = canon(mul_result_i);
                  out_valid_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  i_d     = i_q - 8'd1;
                  phase_d = PH_SQR;
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         phase_q     <= PH_SQR;
         x_q         <= '0;
         r_q         <= '0;
         i_q         <= '0;
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         x_q         <= x_d;
         r_q         <= r_d;
         i_q         <= i_d;
         cnt_q       <= cnt_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_fe_inv.sv
// Bench for fe_inv: two instances (multiplier latency 3 and 5) each driven by a
// bit-accurate field multiplier model; results checked through a scoreboard queue.
module tb_fe_inv;

   localparam logic [254:0] P    = 255'h0 - 255'd19;
   localparam logic [254:0] INV2 = (255'd1 << 254) - 255'd9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n     [2];
   logic         in_valid  [2];
   logic [254:0] in_data   [2];
   logic         in_ready  [2];
   logic         out_valid [2];
   logic         out_ready [2];
   logic [254:0] out_data  [2];
   logic         busy      [2];
   logic [255:0] mul_a     [2];
   logic [255:0] mul_b     [2];
   logic [254:0] mul_res   [2];

   // the DUT's operand registers serve as the multiplier input stage
   logic [254:0] pipe0 [2];
   logic [254:0] pipe1 [4];
   assign mul_res[0] = pipe0[1];
   assign mul_res[1] = pipe1[3];

   fe_inv #(.MUL_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n[0]),
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
      .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
      .busy_o(busy[0]), .mul_a_o(mul_a[0]), .mul_b_o(mul_b[0]), .mul_result_i(mul_res[0])
   );

   fe_inv #(.MUL_LAT(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n[1]),
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
      .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
      .busy_o(busy[1]), .mul_a_o(mul_a[1]), .mul_b_o(mul_b[1]), .mul_result_i(mul_res[1])
   );

   function automatic logic [254:0] mulmod(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] t;
      t = {256'd0, a} * {256'd0, b};
      t = t % {257'd0, P};
      return t[254:0];
   endfunction

   // multiplier output is < 2^255 but not necessarily < p
   function automatic logic [254:0] mul_model(input logic [255:0] a, input logic [255:0] b);
      logic [254:0] r;
      r = mulmod(a, b);
      return (r < 255'd19) ? (r + P) : r;
   endfunction

   function automatic logic [254:0] golden_inv(input logic [254:0] x);
      logic [254:0] b, r, e;
      b = (x >= P) ? (x - P) : x;
      r = 255'd1;
      e = P - 255'd2;
      for (int k = 0; k < 255; k++) begin
         if (e[k]) r = mulmod({1'b0, r}, {1'b0, b});
         b = mulmod({1'b0, b}, {1'b0, b});
      end
      return r;
   endfunction

   function automatic logic [254:0] rand255();
      logic [255:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[254:0];
   endfunction

   always @(posedge clk) begin
      pipe0[0] <= mul_model(mul_a[0], mul_b[0]);
      pipe0[1] <= pipe0[0];
      pipe1[0] <= mul_model(mul_a[1], mul_b[1]);
      for (int k = 1; k < 4; k++) pipe1[k] <= pipe1[k-1];
   end

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [254:0] data;
      logic [254:0] xin;
      bit           inv;
      longint       acc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   in_flight [2];
   int   busy_gap  [2];
   bit   pv        [2];

   task automatic chk(input string name, input int d, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h want %h", name, d, act, exp);
      end
   endtask

   task automatic fail(input string name, input int d);
      n_cmp++;
      n_bad++;
      $display("FAIL %s dut%0d: got timeout want completion", name, d);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic monitor(input int d);
      exp_t   e;
      longint lat;
      lat = (d == 0) ? 64'd2024 : 64'd3036;
      if (in_flight[d] && !busy[d] && !out_valid[d]) busy_gap[d]++;
      if (out_valid[d] && !pv[d]) begin
         if (qsize(d) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out dut%0d: got out_valid 1 want 0", d);
         end else begin
            e = (d == 0) ? q0[0] : q1[0];
            chk("latency", d, 256'(cyc - e.acc), 256'(lat));
            chk("busy_drop", d, 256'(busy[d]), 256'd0);
            chk("busy_thru", d, 256'(busy_gap[d]), 256'd0);
         end
         in_flight[d] = 1'b0;
         busy_gap[d]  = 0;
      end
      if (out_valid[d] && out_ready[d] && qsize(d) > 0) begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk("out_data", d, 256'(out_data[d]), 256'(e.data));
         if (e.inv) chk("inv_prod", d, 256'(mulmod({1'b0, out_data[d]}, {1'b0, e.xin})), 256'd1);
      end
      pv[d] = out_valid[d];
   endtask

   always @(negedge clk) begin
      monitor(0);
      monitor(1);
   end

   task automatic drive_accept(input int d, input logic [254:0] x, input logic [254:0] expv, input bit inv);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      in_valid[d] = 1'b1;
      in_data[d]  = x;
      for (int k = 0; k < 5000 && !ok; k++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            e.data = expv;
            e.xin  = x;
            e.inv  = inv;
            e.acc  = cyc + 1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            ok = 1'b1;
         end
      end
      if (!ok) fail("accept_timeout", d);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      if (ok) in_flight[d] = 1'b1;
   endtask

   task automatic wait_done(input int d);
      for (int k = 0; k < 5000; k++) begin
         if (qsize(d) == 0) break;
         @(negedge clk);
      end
      if (qsize(d) != 0) begin
         fail("done_timeout", d);
         if (d == 0) q0.delete(); else q1.delete();
      end
   endtask

   task automatic run_op(input int d, input logic [254:0] x, input logic [254:0] expv, input bit inv);
      drive_accept(d, x, expv, inv);
      wait_done(d);
   endtask

   task automatic chk_reset(input int d);
      chk("rst_in_ready", d, 256'(in_ready[d]), 256'd1);
      chk("rst_out_valid", d, 256'(out_valid[d]), 256'd0);
      chk("rst_out_data", d, 256'(out_data[d]), 256'd0);
      chk("rst_busy", d, 256'(busy[d]), 256'd0);
      chk("rst_mul_a", d, mul_a[d], 256'd0);
      chk("rst_mul_b", d, mul_b[d], 256'd0);
   endtask

   task automatic run_random(input int d, input int n);
      logic [254:0] x, g;
      for (int k = 0; k < n; k++) begin
         x = rand255();
         g = golden_inv(x);
         run_op(d, x, g, g != 255'd0);
      end
   endtask

   task automatic backpressure();
      logic [254:0] hold;
      int           bad;
      bit           seen;
      bad  = 0;
      seen = 1'b0;
      out_ready[0] = 1'b0;
      drive_accept(0, 255'd7, golden_inv(255'd7), 1'b1);
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(negedge clk);
         seen = out_valid[0];
      end
      if (!seen) fail("bp_valid_timeout", 0);
      hold = out_data[0];
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      in_data[0]  = 255'd9;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (out_data[0] !== hold || in_ready[0] !== 1'b0 || busy[0] !== 1'b0 || out_valid[0] !== 1'b1) bad++;
      end
      chk("bp_hold", 0, 256'(bad), 256'd0);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_ready_during_hs", 0, 256'(in_ready[0]), 256'd0);
      @(negedge clk);
      chk("bp_ready_next", 0, 256'(in_ready[0]), 256'd1);
      begin
         exp_t e;
         e.data = golden_inv(255'd9);
         e.xin  = 255'd9;
         e.inv  = 1'b1;
         e.acc  = cyc + 1;
         q0.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid[0]  = 1'b0;
      in_flight[0] = 1'b1;
      @(negedge clk);
      chk("bp_accepted", 0, 256'(busy[0]), 256'd1);
      wait_done(0);
   endtask

   task automatic reset_midway();
      drive_accept(0, 255'd5, golden_inv(255'd5), 1'b1);
      repeat (999) @(posedge clk);
      #2;
      rst_n[0] = 1'b0;
      q0.delete();
      in_flight[0] = 1'b0;
      busy_gap[0]  = 0;
      #1;
      chk_reset(0);
      @(posedge clk);
      #2;
      rst_n[0] = 1'b1;
      run_op(0, 255'd3, golden_inv(255'd3), 1'b1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d]     = 1'b0;
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b1;
         in_flight[d] = 1'b0;
         busy_gap[d]  = 0;
         pv[d]        = 1'b0;
      end
      #1;
      chk_reset(0);
      chk_reset(1);
      repeat (2) @(posedge clk);
      #3;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      fork
         begin
            run_op(0, 255'd1, 255'd1, 1'b0);
            run_op(0, 255'd2, INV2, 1'b0);
            run_op(0, P - 255'd1, P - 255'd1, 1'b0);
            run_op(0, 255'd0, 255'd0, 1'b0);
            run_op(0, P, 255'd0, 1'b0);
            run_op(0, P + 255'd1, 255'd1, 1'b0);
            backpressure();
            reset_midway();
            run_random(0, 20);
         end
         begin
            run_random(1, 20);
         end
      join

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
